// File: rtl/seven_seg_scan_ctrl_if.sv
// Signal bundle between the digit-value producer and the seven-segment scan controller.
// The master drives the BCD word and requests; the slave (controller) drives the display pins.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output enable, digit_data, dp_in,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  enable, digit_data, dp_in,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display with blanking gaps.
// Optional leading-zero suppression is compiled in with SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;
  logic                    take_snap;

  // Active-low {a,b,c,d,e,f,g}; non-BCD codes render as a blank digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd_q, msd_d;

  // Most significant non-zero digit; 0 when the whole word is zero so digit 0 always shows.
  function automatic logic [IDX_W-1:0] find_msd(input logic [4*NUM_DIGITS-1:0] data);
    find_msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (data[4*i +: 4] != 4'd0) find_msd = IDX_W'(i);
    end
  endfunction
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    snap_data_d  = snap_data_q;
    snap_dp_d    = snap_dp_q;
    frame_done_d = 1'b0;
    take_snap    = 1'b0;
    seg_d        = 7'b1111111;
    dp_d         = 1'b1;
    an_d         = '1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          take_snap = 1'b1;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = S_BLANK;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ON: begin
        if (cnt_q == DIGIT_LAST) begin
          cnt_d = '0;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_BLANK;
          end else begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            if (bus.enable) begin
              take_snap = 1'b1;
              state_d   = S_BLANK;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_snap) begin
      snap_data_d = bus.digit_data;
      snap_dp_d   = bus.dp_in;
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    msd_d = msd_q;
    if (take_snap) msd_d = find_msd(bus.digit_data);
`endif

    // Pins are driven from the next state so anode and segments switch on the same edge.
    if (state_d == S_ON) begin
      an_d[idx_d] = 1'b0;
      seg_d       = seg_decode(snap_data_d[{idx_d, 2'b00} +: 4]);
      dp_d        = ~snap_dp_d[idx_d];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (idx_d > msd_d) seg_d = 7'b1111111;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) msd_q <= '0;
    else        msd_q <= msd_d;
  end
`endif

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus queues the expected lit slots,
// a negedge monitor pops and compares each slot as the display presents it.
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DC = 4;
  localparam int BC = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic clk;
  logic rst_n;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  slot_t exp_q[$];
  slot_t cur;
  int    n_pass  = 0;
  int    n_total = 0;
  int    cyc     = 0;
  int    lit     = 0;
  bit    in_slot = 0;
  bit    fd_prev = 0;
  int    fd_count = 0;
  int    last_fd  = 0;
  int    prev_fd  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_slot(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    slot_t s;
    s.an  = an;
    s.seg = seg;
    s.dp  = dp;
    exp_q.push_back(s);
  endtask

  // Monitor: a lit slot must match its queued expectation for every cycle and last DC cycles.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_slot = 0;
      lit     = 0;
      fd_prev = 0;
    end else begin
      if (bus.frame_done) begin
        check("fd_single_pulse", 32'(fd_prev), 32'd0);
        fd_count++;
        prev_fd = last_fd;
        last_fd = cyc;
      end
      fd_prev = bus.frame_done;
      if (bus.an != 4'b1111) begin
        if (!in_slot) begin
          if (exp_q.size() == 0) check("unexpected_slot", 32'(exp_q.size()), 32'd1);
          else cur = exp_q.pop_front();
          in_slot = 1;
          lit     = 0;
        end
        lit++;
        check("slot_an", 32'(bus.an), 32'(cur.an));
        check("slot_seg", 32'(bus.seg), 32'(cur.seg));
        check("slot_dp", 32'(bus.dp), 32'(cur.dp));
      end else begin
        if (in_slot) begin
          check("slot_len", 32'(lit), DC);
          in_slot = 0;
        end
        check("dark_seg", 32'(bus.seg), 32'h7f);
        check("dark_dp", 32'(bus.dp), 32'd1);
      end
    end
  end

  task automatic wait_an(input logic [3:0] target, input int max_cyc);
    bit found = 0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk);
      if (bus.an == target) found = 1;
    end
    if (!found) check("wait_an_timeout", 32'(bus.an), 32'(target));
  endtask

  task automatic wait_fd(input int max_cyc);
    bit found = 0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk);
      if (bus.frame_done) found = 1;
    end
    if (!found) check("wait_fd_timeout", 32'(bus.frame_done), 32'd1);
  endtask

  // enable was set at a negedge; the next posedge samples it, an[0] drops BC clocks later.
  task automatic expect_latency();
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("latency_still_blank", 32'(bus.an), 32'hf);
    @(negedge clk);
    check("latency_an0_low", 32'(bus.an), 32'he);
  endtask

  task automatic push_1234();
    push_slot(4'b1110, 7'b1001100, 1'b1);
    push_slot(4'b1101, 7'b0000110, 1'b0);
    push_slot(4'b1011, 7'b0010010, 1'b1);
    push_slot(4'b0111, 7'b1001111, 1'b1);
  endtask

  int fd_before;

  initial begin
    rst_n          = 1'b0;
    bus.enable     = 1'b0;
    bus.digit_data = '0;
    bus.dp_in      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_an", 32'(bus.an), 32'hf);
    check("idle_seg", 32'(bus.seg), 32'h7f);
    check("idle_dp", 32'(bus.dp), 32'd1);
    check("idle_fd", 32'(bus.frame_done), 32'd0);

    // Scan sequence: two back-to-back frames of 1234 with dp on digit 1.
    push_1234();
    bus.digit_data = 16'h1234;
    bus.dp_in      = 4'b0010;
    bus.enable     = 1'b1;
    expect_latency();
    push_1234();
    wait_fd(40);

    // Snapshot: 9999 applied during digit 1 of frame B must wait for frame C.
    wait_an(4'b1101, 40);
    bus.digit_data = 16'h9999;
    push_slot(4'b1110, 7'b0000100, 1'b1);
    push_slot(4'b1101, 7'b0000100, 1'b0);
    push_slot(4'b1011, 7'b0000100, 1'b1);
    push_slot(4'b0111, 7'b0000100, 1'b1);
    wait_fd(40);
    #1;
    check("frame_period", 32'(last_fd - prev_fd), 32'd24);

    // enable drop during digit 1 of frame C: frame finishes, one pulse, then dark.
    wait_an(4'b1101, 40);
    bus.enable = 1'b0;
    fd_before  = fd_count;
    wait_fd(40);
    repeat (12) @(negedge clk);
    check("drop_dark_an", 32'(bus.an), 32'hf);
    check("drop_one_pulse", 32'(fd_count), 32'(fd_before + 1));

    // Invalid nibble A in digit 1.
    bus.digit_data = 16'h00A0;
    bus.dp_in      = 4'b0000;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    push_slot(4'b1110, 7'b0000001, 1'b1);
    push_slot(4'b1101, 7'b1111111, 1'b1);
    push_slot(4'b1011, 7'b1111111, 1'b1);
    push_slot(4'b0111, 7'b1111111, 1'b1);
`else
    push_slot(4'b1110, 7'b0000001, 1'b1);
    push_slot(4'b1101, 7'b1111111, 1'b1);
    push_slot(4'b1011, 7'b0000001, 1'b1);
    push_slot(4'b0111, 7'b0000001, 1'b1);
`endif
    bus.enable = 1'b1;
    expect_latency();
    bus.enable = 1'b0;
    wait_fd(40);

    // 0070 then all-zero: leading-zero behaviour depends on the build.
    bus.digit_data = 16'h0070;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    push_slot(4'b1110, 7'b0000001, 1'b1);
    push_slot(4'b1101, 7'b0001111, 1'b1);
    push_slot(4'b1011, 7'b1111111, 1'b1);
    push_slot(4'b0111, 7'b1111111, 1'b1);
`else
    push_slot(4'b1110, 7'b0000001, 1'b1);
    push_slot(4'b1101, 7'b0001111, 1'b1);
    push_slot(4'b1011, 7'b0000001, 1'b1);
    push_slot(4'b0111, 7'b0000001, 1'b1);
`endif
    bus.enable = 1'b1;
    expect_latency();
    bus.enable = 1'b0;
    wait_fd(40);

    bus.digit_data = 16'h0000;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    push_slot(4'b1110, 7'b0000001, 1'b1);
    push_slot(4'b1101, 7'b1111111, 1'b1);
    push_slot(4'b1011, 7'b1111111, 1'b1);
    push_slot(4'b0111, 7'b1111111, 1'b1);
`else
    push_slot(4'b1110, 7'b0000001, 1'b1);
    push_slot(4'b1101, 7'b0000001, 1'b1);
    push_slot(4'b1011, 7'b0000001, 1'b1);
    push_slot(4'b0111, 7'b0000001, 1'b1);
`endif
    bus.enable = 1'b1;
    expect_latency();
    bus.enable = 1'b0;
    wait_fd(40);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of digit 2's lit time.
    bus.digit_data = 16'h1234;
    bus.dp_in      = 4'b0010;
    push_1234();
    bus.enable = 1'b1;
    wait_an(4'b1011, 60);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_an", 32'(bus.an), 32'hf);
    check("rst_seg", 32'(bus.seg), 32'h7f);
    check("rst_dp", 32'(bus.dp), 32'd1);
    check("rst_fd", 32'(bus.frame_done), 32'd0);
    exp_q.delete();
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_an", 32'(bus.an), 32'hf);
    check("post_rst_seg", 32'(bus.seg), 32'h7f);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-cathode-bus, multi-digit seven-segment display.
- Snapshots a packed BCD word once per frame and cycles the digit anodes with a blanking gap between digits to suppress ghosting.
- Decodes the active nibble onto the shared segment bus.
- Sits between the counter/datapath logic that produces digit values and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=1).
- DIGIT_CYCLES, 100000, clocks each digit is lit (1 ms at 100 MHz); >=1.
- BLANK_CYCLES, 1000, clocks of all-off gap before each digit; >=1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run request; sampled only in IDLE and at frame end.
- digit_data  input  4*NUM_DIGITS  packed BCD; nibble i (bits 4i+3:4i) drives digit i; digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
- seg  output  7  cathodes {a,b,c,d,e,f,g}, bit6=a, active-low.
- dp  output  1  decimal point cathode, active-low.
- an  output  NUM_DIGITS  anode enables, active-low.
- frame_done  output  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset (async, immediate, including mid-operation): state=IDLE, idx=0, cnt=0, seg=7'b1111111, dp=1, an=all 1, frame_done=0, snapshot=0.
- All outputs registered; they change on the same edge the state/idx changes.
- States:
  - IDLE: outputs dark. If enable=1 at an edge: snapshot digit_data/dp_in, idx=0, cnt=0, go to BLANK.
  - BLANK: an=all 1, seg=7F, dp=1, for exactly BLANK_CYCLES clocks, then ON, cnt=0.
  - ON: an[idx]=0, all other an bits 1; seg=decode(snap nibble idx); dp=~snap_dp[idx]; held for exactly DIGIT_CYCLES clocks.
- ON exit:
  - If idx<NUM_DIGITS-1: idx+1, go to BLANK.
  - Else (frame end): idx=0; frame_done=1 for the next single cycle.
    - enable=1: re-snapshot inputs, go to BLANK.
    - enable=0: go to IDLE.
- enable deasserted mid-frame: current frame completes normally, frame_done fires, then IDLE. No truncation.
- Inputs change only at snapshot edges; mid-frame changes to digit_data never appear until the next frame.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) clocks. Latency from enable sampled high to an[0] low = BLANK_CYCLES clocks.
- Decode, active-low, fixed:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - 10–15 = 1111111 (blank); anode still asserted, dp still honoured.
- Never more than one an bit low in any cycle. No cycle has an anode low while seg carries the previous digit's pattern.
- Counter width = clog2(max(DIGIT_CYCLES,BLANK_CYCLES)); cnt wraps only via explicit reload, never by overflow.

Optional Feature:
- Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: at each snapshot, compute msd = highest index with nonzero nibble (0 if all zero). During ON, digits with idx>msd output seg=1111111, but an and dp behave normally. Digit 0 is always shown.
- Undefined: every digit decoded literally, leading zeros displayed. No extra logic is synthesised.

Test Plan:
(All tests use NUM_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=2.)
1. Reset: assert rst_n=0 asynchronously mid-ON of digit 2 -> same instant seg=7F, an=4'b1111, dp=1, frame_done=0. After release with enable=0 -> stays dark.
2. Scan sequence: digit_data=16'h1234, dp_in=4'b0010, enable=1 -> an sequence per 6-clock slot:
   - 2 cycles 1111, then 4 cycles 1110 with seg=1001100.
   - Then 1101 with seg=0000110, dp=0.
   - Then 1011 with seg=0010010.
   - Then 0111 with seg=1001111.
   - frame_done pulses every 24 clocks.
3. Snapshot: change digit_data to 16'h9999 during digit 1 of a frame -> remaining digits still show 1,2. Next frame shows 0000100 on all digits.
4. enable drop: deassert during digit 1 -> digits 2,3 still shown, frame_done pulses once, then an=1111 held. Re-assert -> an[0] low exactly 2 clocks after enable sampled.
5. Invalid nibble: digit_data=16'h00A0 -> digit 1 slot has an=1101, seg=1111111. Other digits show 0000001 (macro undefined).
6. Macro defined: digit_data=16'h0070 -> digits 3,2 seg=1111111 with anode asserted, digit 1=0001111, digit 0=0000001. digit_data=0 -> only digit 0 shows 0000001.
